// File: rtl/keypad_scanner_if.sv
// Purpose : keypad pins plus the decoded-key outputs of keypad_scanner, bundled as one port.
// Latency : n/a (wires only).
// Backpressure: none; key_valid is a one-cycle pulse the consumer must take when it appears.
// Signals: rows (keypad rows, active-low), cols (column drives, active-low),
//          key_code (last accepted hex key), key_valid (accept pulse), key_held (key down).
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  rows,
    output cols,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output rows,
    input  cols,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// Purpose : scans a 4x4 active-low keypad, debounces press/release, reports each key once.
// Latency : key_valid DEBOUNCE_CNT cycles after the scan sample + 1; key_held drops DEBOUNCE_CNT after release seen.
// Backpressure: none; key_valid pulses once per press and is not repeated while the key is held.
// Ports: int_osc (clock), reset (async, active-low), kp (master modport: rows in;
//        cols, key_code, key_valid, key_held out).
module keypad_scanner #(
  parameter int SCAN_DIV     = 24000,
  parameter int DEBOUNCE_CNT = 480000
) (
  input  logic             int_osc,
  input  logic             reset,
  keypad_scanner_if.master kp
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t        state;
  logic [3:0]    rows_meta;
  logic [3:0]    rs;
  logic [1:0]    col;
  logic [DW-1:0] dwell;
  logic [SW-1:0] stable;
  logic [3:0]    rpat;
  logic [1:0]    rrow;
  logic [1:0]    ccap;
  logic [3:0]    key_code_q;
  logic          key_valid_q;
  logic          key_held_q;

  // Index of the single low bit; only meaningful when exactly one bit is low.
  function automatic logic [1:0] low_row(input logic [3:0] p);
    casez (p)
      4'b???0: low_row = 2'd0;
      4'b??01: low_row = 2'd1;
      4'b?011: low_row = 2'd2;
      default: low_row = 2'd3;
    endcase
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'b00_00: key_map = 4'h1;
      4'b00_01: key_map = 4'h2;
      4'b00_10: key_map = 4'h3;
      4'b00_11: key_map = 4'hA;
      4'b01_00: key_map = 4'h4;
      4'b01_01: key_map = 4'h5;
      4'b01_10: key_map = 4'h6;
      4'b01_11: key_map = 4'hB;
      4'b10_00: key_map = 4'h7;
      4'b10_01: key_map = 4'h8;
      4'b10_10: key_map = 4'h9;
      4'b10_11: key_map = 4'hC;
      4'b11_00: key_map = 4'hE;
      4'b11_01: key_map = 4'h0;
      4'b11_10: key_map = 4'hF;
      default:  key_map = 4'hD;
    endcase
  endfunction

  // Rows are asynchronous to int_osc; idle (pulled-up) value is all ones.
  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      rows_meta <= 4'hF;
      rs        <= 4'hF;
    end else begin
      rows_meta <= kp.rows;
      rs        <= rows_meta;
    end
  end

  always_ff @(posedge int_osc or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      col         <= 2'd0;
      dwell       <= '0;
      stable      <= '0;
      rpat        <= 4'hF;
      rrow        <= 2'd0;
      ccap        <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            // Zero or multiple low rows are ambiguous: move on instead of guessing.
            if ($countones(~rs) == 1) begin
              rpat   <= rs;
              rrow   <= low_row(rs);
              ccap   <= col;
              stable <= '0;
              state  <= DEBOUNCE;
            end else begin
              col <= col + 2'd1;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        DEBOUNCE: begin
          if (rs != rpat) begin
            // Bounce: retry the same column from a fresh dwell.
            dwell <= '0;
            state <= SCAN;
          end else if (stable == STABLE_LAST) begin
            stable      <= '0;
            key_code_q  <= key_map(rrow, ccap);
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
            state       <= HELD;
          end else begin
            stable <= stable + SW'(1);
          end
        end
        HELD: begin
          if (rs[rrow]) begin
            stable <= '0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          if (!rs[rrow]) begin
            // Release bounce: back to HELD without a new pulse.
            stable <= '0;
            state  <= HELD;
          end else if (stable == STABLE_LAST) begin
            stable     <= '0;
            dwell      <= '0;
            key_held_q <= 1'b0;
            col        <= col + 2'd1;
            state      <= SCAN;
          end else begin
            stable <= stable + SW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  assign kp.cols      = ~(4'b0001 << col);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Purpose : randomized + directed scoreboard bench for keypad_scanner with a keypad matrix model.
// Latency : n/a.
// Backpressure: n/a.
module tb_keypad_scanner;
  localparam int SD  = 8;
  localparam int DEB = 16;

  logic int_osc;
  logic reset;
  keypad_scanner_if kp_if ();

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB)) dut (
    .int_osc (int_osc),
    .reset   (reset),
    .kp      (kp_if.master)
  );

  initial int_osc = 1'b0;
  always #5 int_osc = ~int_osc;

  typedef struct {
    logic [3:0] code;
    int         lo;
    int         hi;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  logic prev_valid = 1'b0;

  // pressed[r][c] = 1 means the key at row r, column c is down.
  logic [3:0][3:0] pressed = '0;

  logic [3:0] kmap [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Keypad matrix: a row is pulled low by any pressed key on a driven (low) column.
  always_comb begin
    logic [3:0] rv;
    rv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !kp_if.cols[c]) rv[r] = 1'b0;
    kp_if.rows = rv;
  end

  // Edges seen since the last reset deassertion.
  always @(posedge int_osc) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [3:0] col_pat(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (c % 4));
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected in [%0d,%0d]", name, act, lo, hi);
    end
  endtask

  // Monitor: pops the scoreboard on every key_valid pulse.
  always @(negedge int_osc) begin
    if (reset) begin
      chk("cols_one_low", $countones(~kp_if.cols), 1);
      if (kp_if.key_valid) begin
        chk("valid_not_back_to_back", prev_valid, 0);
        chk("held_with_valid", kp_if.key_held, 1);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got key_code %0h at cycle %0d, expected no pulse", kp_if.key_code, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("key_code", kp_if.key_code, e.code);
          chk_range("valid_cycle", cyc, e.lo, e.hi);
        end
      end
      prev_valid = kp_if.key_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic start(input logic [3:0][3:0] p);
    reset   = 1'b0;
    pressed = p;
    repeat (3) @(negedge int_osc);
    reset = 1'b1;
  endtask

  task automatic wait_cyc(input int t);
    for (int i = 0; i < 2000 && cyc < t; i++) @(negedge int_osc);
  endtask

  task automatic wait_held_fall(input string name, input int exp_cyc);
    int i;
    for (i = 0; i < 300; i++) begin
      @(negedge int_osc);
      if (!kp_if.key_held) break;
    end
    if (i == 300) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: key_held still 1, expected 0 by cycle %0d", name, exp_cyc);
    end else begin
      chk(name, cyc, exp_cyc);
    end
  endtask

  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk("cols_rotation", kp_if.cols, col_pat(cyc / SD));
      @(negedge int_osc);
    end
  endtask

  // Press one key from reset, hold it, release cleanly, check accept and release timing.
  task automatic press_key(input int r, input int c, input int hold);
    logic [3:0][3:0] p;
    int t;
    int rel;
    p = '0;
    p[r][c] = 1'b1;
    t = (c + 1) * SD + DEB;
    sb.push_back('{kmap[r][c], t, t});
    start(p);
    wait_cyc(t + 1);
    chk("sb_drained", sb.size(), 0);
    chk("held_after_accept", kp_if.key_held, 1);
    chk("cols_frozen_accept", kp_if.cols, col_pat(c));
    wait_cyc(t + hold);
    chk("cols_frozen_held", kp_if.cols, col_pat(c));
    rel = cyc;
    pressed = '0;
    wait_held_fall("release_latency", rel + 3 + DEB);
    chk("cols_advance_on_release", kp_if.cols, col_pat(c + 1));
  endtask

  initial begin
    logic [3:0][3:0] p;
    int rel;
    reset = 1'b0;
    @(negedge int_osc);
    #1;
    chk("reset_cols", kp_if.cols, 4'b1110);
    chk("reset_key_code", kp_if.key_code, 0);
    chk("reset_key_valid", kp_if.key_valid, 0);
    chk("reset_key_held", kp_if.key_held, 0);

    // Idle rotation.
    start('0);
    check_idle(40);

    // Clean press of key 5 and corner keys.
    press_key(1, 1, 100);
    press_key(0, 3, 10);
    press_key(3, 3, 10);
    press_key(3, 0, 10);

    // Bounce on press: row1/col1 toggles every 3 cycles for 30 cycles.
    sb.push_back('{4'h5, 30 + DEB, 300});
    start('0);
    for (int k = 0; k < 30; k++) begin
      pressed[1][1] = ((k / 3) % 2) == 0;
      @(negedge int_osc);
    end
    pressed[1][1] = 1'b1;
    wait_cyc(300);
    chk("bounce_press_accepted", sb.size(), 0);
    rel = cyc;
    pressed = '0;
    wait_held_fall("bounce_press_release", rel + 3 + DEB);

    // Bounce on release of key 0.
    p = '0;
    p[3][1] = 1'b1;
    sb.push_back('{4'h0, 2 * SD + DEB, 2 * SD + DEB});
    start(p);
    wait_cyc(50);
    chk("key0_accepted", sb.size(), 0);
    rel = cyc;
    pressed = '0;
    repeat (5) @(negedge int_osc);
    pressed[3][1] = 1'b1;
    repeat (5) @(negedge int_osc);
    chk("held_through_bounce", kp_if.key_held, 1);
    pressed = '0;
    wait_held_fall("bounce_release_latency", rel + 10 + 3 + DEB);

    // Two rows low on col0: never accepted, rotation continues.
    p = '0;
    p[0][0] = 1'b1;
    p[2][0] = 1'b1;
    start(p);
    check_idle(80);
    pressed = '0;

    // Reset during HELD.
    p = '0;
    p[1][1] = 1'b1;
    sb.push_back('{4'h5, 2 * SD + DEB, 2 * SD + DEB});
    start(p);
    wait_cyc(40);
    chk("held_before_reset", kp_if.key_code, 4'h5);
    reset = 1'b0;
    #1;
    chk("rst_held_cols", kp_if.cols, 4'b1110);
    chk("rst_held_code", kp_if.key_code, 0);
    chk("rst_held_valid", kp_if.key_valid, 0);
    chk("rst_held_held", kp_if.key_held, 0);
    pressed = '0;
    repeat (2) @(negedge int_osc);
    reset = 1'b1;
    check_idle(20);

    // Reset during DEBOUNCE: no pulse may ever appear for this press.
    start(p);
    wait_cyc(2 * SD + 4);
    reset = 1'b0;
    #1;
    chk("rst_deb_cols", kp_if.cols, 4'b1110);
    chk("rst_deb_code", kp_if.key_code, 0);
    chk("rst_deb_valid", kp_if.key_valid, 0);
    chk("rst_deb_held", kp_if.key_held, 0);
    pressed = '0;
    repeat (2) @(negedge int_osc);
    reset = 1'b1;
    check_idle(40);

    // Randomized single-key presses.
    for (int n = 0; n < 10; n++)
      press_key($urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(40, 5));

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
